lock_attempt_ctrl: RTL and testbench
====================================

# lock_attempt_ctrl

Attempt-limiting controller that sits directly downstream of the 4-bit code comparator in the combination-lock tile. Each attempt is a one-cycle `try_i` strobe with the comparator's `match_i` result. A correct code opens the lock for a fixed hold window. Wrong codes are counted, and `MAX_FAIL` consecutive failures force a timed lockout during which all attempts are ignored.

## Interface
Parameters:
- `MAX_FAIL`, default 3: consecutive failures that trigger lockout; legal range 1..2^FAIL_W−1.
- `FAIL_W`, default 2: width of the failure counter.
- `UNLOCK_CYCLES`, default 256: clock cycles `unlocked_o` stays high after a correct attempt; legal range 1..2^TMR_W.
- `LOCKOUT_CYCLES`, default 1024: clock cycles `lockout_o` stays high; legal range 1..2^TMR_W.
- `TMR_W`, default 16: width of the shared down-timer.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `try_i`, in, 1: attempt strobe; one cycle per attempt.
- `match_i`, in, 1: comparator result; sampled only when `try_i`=1.
- `relock_i`, in, 1: user request to relock early.
- `accept_o`, out, 1: high when in IDLE, meaning attempts are being evaluated.
- `unlocked_o`, out, 1: lock open.
- `lockout_o`, out, 1: lockout window active.
- `fail_o`, out, 1: one-cycle pulse per evaluated wrong attempt.
- `alarm_o`, out, 1: one-cycle pulse on entry to LOCKOUT.
- `fail_cnt_o`, out, FAIL_W: current consecutive-failure count.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, timer=0, fail count=0, `accept_o`=1, and every other output 0.
- States are IDLE, UNLOCKED and LOCKOUT.
- IDLE:
  - `try_i`=1 and `match_i`=1: go to UNLOCKED, load timer with UNLOCK_CYCLES−1, clear fail count.
  - `try_i`=1 and `match_i`=0: pulse `fail_o`, increment fail count.
  - If the incremented count equals MAX_FAIL: go to LOCKOUT, load timer with LOCKOUT_CYCLES−1, pulse `alarm_o` in the same cycle as `fail_o`. `fail_cnt_o` holds MAX_FAIL for the whole of LOCKOUT.
  - `try_i`=0: hold state.
- UNLOCKED:
  - `try_i` is ignored; no fail pulse, no count change.
  - If `relock_i`=1, go to IDLE immediately; this takes priority over the timer.
  - Otherwise, when timer=0 go to IDLE; else decrement the timer.
- LOCKOUT:
  - `try_i` and `relock_i` are ignored.
  - When timer=0, go to IDLE and clear the fail count; else decrement the timer.
- `relock_i` has no effect in IDLE or LOCKOUT.
- The fail counter never wraps. It saturates at MAX_FAIL because reaching MAX_FAIL always enters LOCKOUT.
- The timer is TMR_W bits, unsigned, and counts down to 0 with no wrap. Reload happens only on state entry.

## Timing
- `try_i`+`match_i` at edge N:
  - `unlocked_o` is high from N+1 for exactly UNLOCK_CYCLES cycles.
  - `accept_o` is low over the same cycles.
- Failing try at edge N: `fail_o` is high only for cycle N+1, and `fail_cnt_o` is updated at N+1.
- Failing try at edge N that reaches MAX_FAIL:
  - `lockout_o` is high from N+1 for exactly LOCKOUT_CYCLES cycles.
  - `alarm_o` is high for cycle N+1 only.
  - `accept_o` returns to 1 together with the fall of `lockout_o`, and `fail_cnt_o` becomes 0 at the same time.
- `relock_i` sampled in UNLOCKED at edge M: `unlocked_o` is low from M+1.
- A `try_i` in the same cycle that IDLE is re-entered is not evaluated. Attempts are accepted from the first cycle `accept_o`=1.
- Back-to-back `try_i` on consecutive IDLE cycles is legal; each one is evaluated.
- `rst_n` falling in any state immediately forces the reset values, without waiting for a clock edge. Operation resumes on the first edge after `rst_n` rises.

## Test plan
- Reset, then a matching try at cycle 10 (defaults): `unlocked_o` is 1 for cycles 11..266 and 0 at 267; `fail_cnt_o`=0.
- Three wrong tries on consecutive cycles:
  - `fail_o` pulses three times, and `fail_cnt_o` reads 1, 2, 3.
  - `alarm_o` is a single pulse together with the third fail.
  - `lockout_o` is high for exactly 1024 cycles, and tries applied during it produce no `fail_o`.
  - After lockout, `fail_cnt_o`=0.
- Two wrong tries then a correct one: unlock occurs, `fail_cnt_o` drops to 0, and one more wrong try reads 1.
- Unlock, then `relock_i` 5 cycles later: `unlocked_o` falls on the next cycle and `accept_o`=1; a following correct try reopens the lock.
- Assert `rst_n`=0 asynchronously mid-LOCKOUT and mid-UNLOCKED: `lockout_o` and `unlocked_o` drop with no clock edge, and `fail_cnt_o`=0.
- Parameter edge case, UNLOCK_CYCLES=1 and LOCKOUT_CYCLES=1 with MAX_FAIL=1: each window lasts exactly one cycle, and one wrong try enters LOCKOUT directly.

Source files
------------

// File: rtl/lock_attempt_ctrl_if.sv
// Attempt/lock status bundle between the code comparator
// side and the attempt-limiting controller.
interface lock_attempt_ctrl_if #(
  parameter int FAIL_W = 2
) ();
  logic              try_i;
  logic              match_i;
  logic              relock_i;
  logic              accept_o;
  logic              unlocked_o;
  logic              lockout_o;
  logic              fail_o;
  logic              alarm_o;
  logic [FAIL_W-1:0] fail_cnt_o;

  modport master (
    output try_i,
    output match_i,
    output relock_i,
    input  accept_o,
    input  unlocked_o,
    input  lockout_o,
    input  fail_o,
    input  alarm_o,
    input  fail_cnt_o
  );

  modport slave (
    input  try_i,
    input  match_i,
    input  relock_i,
    output accept_o,
    output unlocked_o,
    output lockout_o,
    output fail_o,
    output alarm_o,
    output fail_cnt_o
  );
endinterface

// File: rtl/lock_attempt_ctrl.sv
// Attempt limiter: opens the lock for a hold window on a
// correct code, forces a timed lockout after repeated misses.
module lock_attempt_ctrl #(
  parameter int MAX_FAIL       = 3,
  parameter int FAIL_W         = 2,
  parameter int UNLOCK_CYCLES  = 256,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int TMR_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  lock_attempt_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UNL  = 2'd1,
    S_LKO  = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] UNL_LD =
    TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LKO_LD =
    TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0] MAX_C =
    FAIL_W'(MAX_FAIL);

  state_t            state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [TMR_W-1:0]  tmr_d;
  logic [FAIL_W-1:0] fail_q;
  logic [FAIL_W-1:0] fail_d;
  logic              accept_q;
  logic              unl_q;
  logic              lko_q;
  logic              failp_q;
  logic              alarm_q;

  // Candidate next values: timer step and the count after a miss.
  assign tmr_d  = tmr_q - TMR_W'(1);
  assign fail_d = fail_q + FAIL_W'(1);

  // Single FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      fail_q   <= '0;
      accept_q <= 1'b1;
      unl_q    <= 1'b0;
      lko_q    <= 1'b0;
      failp_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      failp_q <= 1'b0;
      alarm_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.try_i) begin
            if (bus.match_i) begin
              state_q  <= S_UNL;
              tmr_q    <= UNL_LD;
              fail_q   <= '0;
              unl_q    <= 1'b1;
              accept_q <= 1'b0;
            end else begin
              failp_q <= 1'b1;
              fail_q  <= fail_d;
              if (fail_d == MAX_C) begin
                state_q  <= S_LKO;
                tmr_q    <= LKO_LD;
                lko_q    <= 1'b1;
                alarm_q  <= 1'b1;
                accept_q <= 1'b0;
              end
            end
          end
        end
        S_UNL: begin
          if (bus.relock_i || tmr_q == '0) begin
            state_q  <= S_IDLE;
            unl_q    <= 1'b0;
            accept_q <= 1'b1;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        S_LKO: begin
          if (tmr_q == '0) begin
            state_q  <= S_IDLE;
            fail_q   <= '0;
            lko_q    <= 1'b0;
            accept_q <= 1'b1;
          end else begin
            tmr_q <= tmr_d;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          tmr_q    <= '0;
          fail_q   <= '0;
          unl_q    <= 1'b0;
          lko_q    <= 1'b0;
          accept_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.accept_o   = accept_q;
  assign bus.unlocked_o = unl_q;
  assign bus.lockout_o  = lko_q;
  assign bus.fail_o     = failp_q;
  assign bus.alarm_o    = alarm_q;
  assign bus.fail_cnt_o = fail_q;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Randomized bench: default DUT and a 1-cycle-window,
// single-miss DUT, both checked against a window model.
module tb_lock_attempt_ctrl;

  logic clk;
  logic rst_n;

  lock_attempt_ctrl_if #(.FAIL_W(2)) b0 ();
  lock_attempt_ctrl_if #(.FAIL_W(1)) b1 ();

  lock_attempt_ctrl dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  lock_attempt_ctrl #(
    .MAX_FAIL       (1),
    .FAIL_W         (1),
    .UNLOCK_CYCLES  (1),
    .LOCKOUT_CYCLES (1),
    .TMR_W          (4)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int p_u[2]  = '{256, 1};
  int p_l[2]  = '{1024, 1};
  int p_mx[2] = '{3, 1};

  int open_left[2];
  int lock_left[2];
  int fails[2];
  bit fp[2];
  bit al[2];

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      open_left[i] = 0;
      lock_left[i] = 0;
      fails[i]     = 0;
      fp[i]        = 1'b0;
      al[i]        = 1'b0;
    end
  endtask

  task automatic m_step(bit t, bit m, bit r);
    for (int i = 0; i < 2; i++) begin
      fp[i] = 1'b0;
      al[i] = 1'b0;
      if (open_left[i] > 0) begin
        if (r) open_left[i] = 0;
        else   open_left[i]--;
      end else if (lock_left[i] > 0) begin
        lock_left[i]--;
        if (lock_left[i] == 0) fails[i] = 0;
      end else if (t) begin
        if (m) begin
          open_left[i] = p_u[i];
          fails[i]     = 0;
        end else begin
          fp[i] = 1'b1;
          fails[i]++;
          if (fails[i] == p_mx[i]) begin
            lock_left[i] = p_l[i];
            al[i]        = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("d0.accept", int'(b0.accept_o),
        int'(open_left[0] == 0 && lock_left[0] == 0));
    chk("d0.unlocked", int'(b0.unlocked_o),
        int'(open_left[0] > 0));
    chk("d0.lockout", int'(b0.lockout_o),
        int'(lock_left[0] > 0));
    chk("d0.fail", int'(b0.fail_o), int'(fp[0]));
    chk("d0.alarm", int'(b0.alarm_o), int'(al[0]));
    chk("d0.fail_cnt", int'(b0.fail_cnt_o), fails[0]);
    chk("d1.accept", int'(b1.accept_o),
        int'(open_left[1] == 0 && lock_left[1] == 0));
    chk("d1.unlocked", int'(b1.unlocked_o),
        int'(open_left[1] > 0));
    chk("d1.lockout", int'(b1.lockout_o),
        int'(lock_left[1] > 0));
    chk("d1.fail", int'(b1.fail_o), int'(fp[1]));
    chk("d1.alarm", int'(b1.alarm_o), int'(al[1]));
    chk("d1.fail_cnt", int'(b1.fail_cnt_o), fails[1]);
  endtask

  task automatic tick(bit t, bit m, bit r);
    b0.try_i    = t;
    b0.match_i  = m;
    b0.relock_i = r;
    b1.try_i    = t;
    b1.match_i  = m;
    b1.relock_i = r;
    @(posedge clk);
    m_step(t, m, r);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_rst();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    b0.try_i = 1'b0; b0.match_i = 1'b0; b0.relock_i = 1'b0;
    b1.try_i = 1'b0; b1.match_i = 1'b0; b1.relock_i = 1'b0;
    m_reset();
    #1;
    rst_n = 1'b0;
    #2;
    check_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // matching try after reset, full hold window
    idle(9);
    tick(1'b1, 1'b1, 1'b0);
    idle(270);

    // three misses, tries ignored during lockout
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 1030; k++)
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(3);

    // two misses then a correct code clears the count
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    idle(260);
    tick(1'b1, 1'b0, 1'b0);
    idle(2);

    // early relock then reopen
    tick(1'b1, 1'b1, 1'b0);
    idle(5);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    idle(4);

    // async reset mid-unlock and mid-lockout
    async_rst();
    tick(1'b1, 1'b1, 1'b0);
    idle(3);
    async_rst();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    idle(10);
    async_rst();
    idle(2);

    // random traffic
    for (int k = 0; k < 6000; k++) begin
      bit t, m, r;
      t = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 19) == 0);
      tick(t, m, r);
      if ($urandom_range(0, 1999) == 0) async_rst();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
